sobel_window_sequencer: RTL and testbench
=========================================

Name: sobel_window_sequencer

Overview:
Frame-level scheduler for the Sobel stage. It walks a grayscale frame held in pixel memory and fetches one 3-pixel vertical column at a time, top to bottom, left to right, for each output row. For every output row it streams the first three columns (9 pixels), then one column (3 pixels) per further window. It drives the Sobel stage's start/pixel-ready interface and signals frame completion.

Parameters:
PIXEL_WIDTH, 8, bits per grayscale pixel
DIM_BITS, 10, width of the frame width/height configuration inputs
ADDR_BITS, 20, pixel memory address width (word = one pixel)

Ports:
clk_i  in  1  system clock
nreset_i  in  1  asynchronous active-low reset
start_frame_i  in  1  single-cycle pulse; starts a frame (ignored unless IDLE)
abort_i  in  1  synchronous abort; return to IDLE next cycle
img_width_i  in  DIM_BITS  frame width W, sampled on accepted start
img_height_i  in  DIM_BITS  frame height H, sampled on accepted start
base_addr_i  in  ADDR_BITS  address of pixel (row 0, col 0), sampled on accepted start
rd_req_o  out  1  memory read request
rd_addr_o  out  ADDR_BITS  read address, stable while rd_req_o high
rd_ack_i  in  1  one-cycle pulse; rd_data_i valid this cycle, completes the request
rd_data_i  in  PIXEL_WIDTH  read data
start_sobel_o  out  1  row-active level to the Sobel stage
px_o  out  PIXEL_WIDTH  pixel to the Sobel stage
px_rdy_o  out  1  one-cycle strobe; px_o valid
busy_o  out  1  high in every state except IDLE
frame_done_o  out  1  one-cycle pulse at frame end
cfg_err_o  out  1  one-cycle pulse; start rejected because W<3 or H<3

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters and address registers 0.
- Config: W, H and base are latched on an accepted start. Later input changes have no effect until the next frame.
- Config error: if W<3 or H<3, assert cfg_err_o for one cycle and stay in IDLE. No reads are issued and frame_done_o stays low.
- Row r (r = 0..H-3) covers source rows r, r+1, r+2.
- Row base registers: top = base + r*W, maintained incrementally with top += W per row. mid = top+W and bot = top+2W are also registers. No multiplier.
- Fetch order per row: for c = 0..W-1, read addresses top+c, mid+c, bot+c.
- Reads per row: 3W. Sobel windows per row: W-2.
- FSM states: IDLE, ROW_START, REQ, EMIT, ROW_GAP, DONE.
  - IDLE -> ROW_START on a valid accepted start.
  - ROW_START (1 cycle): start_sobel_o goes high. Column and pixel counters clear. -> REQ.
  - REQ: rd_req_o=1, rd_addr_o = current address. Hold until rd_ack_i. On ack, capture rd_data_i -> EMIT.
  - EMIT (1 cycle): rd_req_o=0, px_rdy_o=1, px_o = captured data. Advance the in-column index 0..2; at 2, wrap to 0 and increment the column.
    - If more pixels remain in the row -> REQ.
    - Else, if rows remain -> ROW_GAP.
    - Else -> DONE.
  - ROW_GAP (2 cycles): start_sobel_o=0. Advance the row bases by W. -> ROW_START.
  - DONE (1 cycle): start_sobel_o=0, frame_done_o=1. -> IDLE.
- start_sobel_o is high from ROW_START through the last EMIT of the row. It is therefore high at least 1 cycle before the first px_rdy_o of the row, and low at least 3 cycles between rows (ROW_GAP plus the next ROW_START transition).
- Minimum spacing between px_rdy_o strobes is 2 cycles (REQ with immediate ack, then EMIT). Back-to-back strobes never occur.
- Outstanding reads: at most one. rd_ack_i outside REQ is ignored.
- Abort: abort_i in any state forces IDLE next cycle. rd_req_o, start_sobel_o and px_rdy_o go low and frame_done_o is not pulsed. The memory must tolerate a withdrawn request.
- Precedence: abort_i has priority over rd_ack_i in the same cycle; the data is dropped.
- start_frame_i while busy_o=1 is ignored.
- Address arithmetic is modulo 2^ADDR_BITS; wrap is not flagged.
- nreset_i asserted mid-frame: immediate return to the reset state.

Test Plan:
- W=4, H=3, base=0, rd_ack_i one cycle after each req -> rd_addr_o sequence 0,4,8,1,5,9,2,6,10,3,7,11; px_o matches memory[addr]; 12 px_rdy_o strobes; start_sobel_o high throughout; frame_done_o pulses once after the 12th strobe.
- W=5, H=5, base=100 -> 3 rows of 15 reads each (45 total). Row 1 starts at address 105, row 2 at 110. start_sobel_o is low for at least 3 cycles between rows.
- W=2, H=8, start -> cfg_err_o single pulse; busy_o, rd_req_o and frame_done_o stay 0.
- W=4, H=3 with random ack delays of 0-7 cycles -> rd_addr_o stable while rd_req_o is high; same 12-address order; px_rdy_o strobes never adjacent.
- Abort during the 6th REQ, with rd_ack_i in the same cycle -> next cycle IDLE with all outputs 0, no 6th px_rdy_o, no frame_done_o. A new start then replays from address base.
- start_frame_i pulsed mid-frame, and img_width_i changed mid-frame -> no effect; the frame completes with the originally latched W.

Source files
------------

// File: rtl/sobel_window_sequencer_if.sv
// rtl/sobel_window_sequencer_if.sv - control, pixel-memory and Sobel-stage signal bundle for the window sequencer
interface sobel_window_sequencer_if #(
    parameter int PIXEL_WIDTH = 8,
    parameter int DIM_BITS    = 10,
    parameter int ADDR_BITS   = 20
);
    // frame control and configuration
    logic                   start_frame_i;
    logic                   abort_i;
    logic [DIM_BITS-1:0]    img_width_i;
    logic [DIM_BITS-1:0]    img_height_i;
    logic [ADDR_BITS-1:0]   base_addr_i;

    // pixel memory read port
    logic                   rd_req_o;
    logic [ADDR_BITS-1:0]   rd_addr_o;
    logic                   rd_ack_i;
    logic [PIXEL_WIDTH-1:0] rd_data_i;

    // Sobel stage feed and status
    logic                   start_sobel_o;
    logic [PIXEL_WIDTH-1:0] px_o;
    logic                   px_rdy_o;
    logic                   busy_o;
    logic                   frame_done_o;
    logic                   cfg_err_o;

    // sequencer side
    modport master (
        input  start_frame_i, abort_i, img_width_i, img_height_i, base_addr_i,
        input  rd_ack_i, rd_data_i,
        output rd_req_o, rd_addr_o,
        output start_sobel_o, px_o, px_rdy_o, busy_o, frame_done_o, cfg_err_o
    );

    // environment side: controller, pixel memory and Sobel stage
    modport slave (
        output start_frame_i, abort_i, img_width_i, img_height_i, base_addr_i,
        output rd_ack_i, rd_data_i,
        input  rd_req_o, rd_addr_o,
        input  start_sobel_o, px_o, px_rdy_o, busy_o, frame_done_o, cfg_err_o
    );
endinterface

// File: rtl/sobel_window_sequencer.sv
// rtl/sobel_window_sequencer.sv - walks a frame column-by-column in 3-row bands and feeds pixels to the Sobel stage
module sobel_window_sequencer #(
    parameter int PIXEL_WIDTH = 8,
    parameter int DIM_BITS    = 10,
    parameter int ADDR_BITS   = 20
) (
    input  logic                     clk_i,
    input  logic                     nreset_i,
    sobel_window_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW_START,
        S_REQ,
        S_EMIT,
        S_ROW_GAP,
        S_DONE
    } state_t;

    state_t                 state_q;

    // latched frame configuration
    logic [DIM_BITS-1:0]    w_q;
    logic [DIM_BITS-1:0]    h_q;

    // position within the frame: output row, column, row within the column (0..2)
    logic [DIM_BITS-1:0]    row_q;
    logic [DIM_BITS-1:0]    col_q;
    logic [1:0]             sub_q;
    logic                   gap_q;

    // start addresses of the three source rows of the current band
    logic [ADDR_BITS-1:0]   top_q;
    logic [ADDR_BITS-1:0]   mid_q;
    logic [ADDR_BITS-1:0]   bot_q;

    // registered outputs
    logic                   rd_req_q;
    logic [ADDR_BITS-1:0]   rd_addr_q;
    logic                   start_sobel_q;
    logic [PIXEL_WIDTH-1:0] px_q;
    logic                   px_rdy_q;
    logic                   busy_q;
    logic                   frame_done_q;
    logic                   cfg_err_q;

    // next-fetch decode
    logic [ADDR_BITS-1:0]   w_ext;
    logic [ADDR_BITS-1:0]   w_in_ext;
    logic [ADDR_BITS-1:0]   col_nxt_ext;
    logic [ADDR_BITS-1:0]   next_addr;
    logic [DIM_BITS-1:0]    col_nxt;
    logic [1:0]             sub_nxt;
    logic                   last_px;
    logic                   more_rows;
    logic                   cfg_bad;

    // Work out which pixel follows the one just emitted and where it lives
    always_comb begin
        w_ext    = ADDR_BITS'(w_q);
        w_in_ext = ADDR_BITS'(bus.img_width_i);
        cfg_bad  = (bus.img_width_i < DIM_BITS'(3)) || (bus.img_height_i < DIM_BITS'(3));

        last_px   = (sub_q == 2'd2) && (col_q == w_q - DIM_BITS'(1));
        more_rows = (row_q != h_q - DIM_BITS'(3));

        if (sub_q == 2'd2) begin
            sub_nxt = 2'd0;
            col_nxt = col_q + DIM_BITS'(1);
        end else begin
            sub_nxt = sub_q + 2'd1;
            col_nxt = col_q;
        end

        col_nxt_ext = ADDR_BITS'(col_nxt);
        case (sub_nxt)
            2'd0:    next_addr = top_q + col_nxt_ext;
            2'd1:    next_addr = mid_q + col_nxt_ext;
            default: next_addr = bot_q + col_nxt_ext;
        endcase
    end

    // Frame sequencing FSM with registered outputs; abort overrides everything including a same-cycle ack
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q       <= S_IDLE;
            w_q           <= '0;
            h_q           <= '0;
            row_q         <= '0;
            col_q         <= '0;
            sub_q         <= '0;
            gap_q         <= 1'b0;
            top_q         <= '0;
            mid_q         <= '0;
            bot_q         <= '0;
            rd_req_q      <= 1'b0;
            rd_addr_q     <= '0;
            start_sobel_q <= 1'b0;
            px_q          <= '0;
            px_rdy_q      <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else if (bus.abort_i) begin
            state_q       <= S_IDLE;
            rd_req_q      <= 1'b0;
            rd_addr_q     <= '0;
            start_sobel_q <= 1'b0;
            px_q          <= '0;
            px_rdy_q      <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            // strobes last exactly one cycle unless re-asserted below
            px_rdy_q     <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (bus.start_frame_i) begin
                        if (cfg_bad) begin
                            cfg_err_q <= 1'b1;
                        end else begin
                            w_q     <= bus.img_width_i;
                            h_q     <= bus.img_height_i;
                            row_q   <= '0;
                            top_q   <= bus.base_addr_i;
                            mid_q   <= bus.base_addr_i + w_in_ext;
                            bot_q   <= bus.base_addr_i + w_in_ext + w_in_ext;
                            busy_q  <= 1'b1;
                            state_q <= S_ROW_START;
                        end
                    end
                end

                S_ROW_START: begin
                    col_q         <= '0;
                    sub_q         <= 2'd0;
                    start_sobel_q <= 1'b1;
                    rd_req_q      <= 1'b1;
                    rd_addr_q     <= top_q;
                    state_q       <= S_REQ;
                end

                S_REQ: begin
                    if (bus.rd_ack_i) begin
                        px_q     <= bus.rd_data_i;
                        px_rdy_q <= 1'b1;
                        rd_req_q <= 1'b0;
                        state_q  <= S_EMIT;
                    end
                end

                S_EMIT: begin
                    col_q <= col_nxt;
                    sub_q <= sub_nxt;
                    if (!last_px) begin
                        rd_req_q  <= 1'b1;
                        rd_addr_q <= next_addr;
                        state_q   <= S_REQ;
                    end else if (more_rows) begin
                        start_sobel_q <= 1'b0;
                        gap_q         <= 1'b0;
                        state_q       <= S_ROW_GAP;
                    end else begin
                        start_sobel_q <= 1'b0;
                        frame_done_q  <= 1'b1;
                        state_q       <= S_DONE;
                    end
                end

                S_ROW_GAP: begin
                    // two idle cycles between bands; bases slide down one source row at the end
                    if (!gap_q) begin
                        gap_q <= 1'b1;
                    end else begin
                        top_q   <= top_q + w_ext;
                        mid_q   <= mid_q + w_ext;
                        bot_q   <= bot_q + w_ext;
                        row_q   <= row_q + DIM_BITS'(1);
                        state_q <= S_ROW_START;
                    end
                end

                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_req_o      = rd_req_q;
    assign bus.rd_addr_o     = rd_addr_q;
    assign bus.start_sobel_o = start_sobel_q;
    assign bus.px_o          = px_q;
    assign bus.px_rdy_o      = px_rdy_q;
    assign bus.busy_o        = busy_q;
    assign bus.frame_done_o  = frame_done_q;
    assign bus.cfg_err_o     = cfg_err_q;

endmodule

// File: tb/tb_sobel_window_sequencer.sv
// tb/tb_sobel_window_sequencer.sv - scoreboard bench for the Sobel window sequencer
module tb_sobel_window_sequencer;

    localparam int PW = 8;
    localparam int DB = 10;
    localparam int AB = 20;

    logic clk = 1'b0;
    logic nreset = 1'b1;

    always #5 clk = ~clk;

    sobel_window_sequencer_if #(.PIXEL_WIDTH(PW), .DIM_BITS(DB), .ADDR_BITS(AB)) bus();

    sobel_window_sequencer #(.PIXEL_WIDTH(PW), .DIM_BITS(DB), .ADDR_BITS(AB)) dut (
        .clk_i    (clk),
        .nreset_i (nreset),
        .bus      (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [AB-1:0] exp_addr_q[$];
    logic [PW-1:0] exp_px_q[$];
    logic [AB-1:0] got_addr_q[$];

    int strobe_cnt = 0;
    int done_cnt   = 0;
    int err_cnt    = 0;

    bit      resp_en   = 1'b1;
    int      max_delay = 0;
    logic    resp_ack  = 1'b0;
    logic [PW-1:0] resp_data = '0;
    logic    man_ack   = 1'b0;
    logic [PW-1:0] man_data = '0;

    assign bus.rd_ack_i  = resp_en ? resp_ack  : man_ack;
    assign bus.rd_data_i = resp_en ? resp_data : man_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic logic [PW-1:0] mem_px(input logic [AB-1:0] a);
        return a[7:0] ^ a[15:8] ^ {a[19:16], 4'h9} ^ 8'h3C;
    endfunction

    // Reference model: every output row r reads rows r..r+2, column by column, top to bottom
    task automatic push_frame(input int w, input int h, input logic [AB-1:0] base);
        logic [AB-1:0] a;
        for (int r = 0; r <= h - 3; r++)
            for (int c = 0; c < w; c++)
                for (int k = 0; k < 3; k++) begin
                    a = base + AB'((r + k) * w + c);
                    exp_addr_q.push_back(a);
                    exp_px_q.push_back(mem_px(a));
                end
    endtask

    // Pixel memory: acks after a random delay, checks address order and stability
    initial begin : responder
        int wait_left;
        bit held;
        logic [AB-1:0] held_addr;
        wait_left = 0;
        held = 1'b0;
        held_addr = '0;
        forever begin
            @(posedge clk);
            #1;
            resp_ack = 1'b0;
            if (resp_en && nreset && bus.rd_req_o) begin
                if (held) check("rd_addr_stable", bus.rd_addr_o, held_addr);
                if (wait_left == 0) begin
                    check("rd_addr_expected", exp_addr_q.size() > 0, 1);
                    if (exp_addr_q.size() > 0) check("rd_addr", bus.rd_addr_o, exp_addr_q.pop_front());
                    got_addr_q.push_back(bus.rd_addr_o);
                    resp_data = mem_px(bus.rd_addr_o);
                    resp_ack  = 1'b1;
                    held      = 1'b0;
                    wait_left = $urandom_range(max_delay, 0);
                end else begin
                    wait_left--;
                    held      = 1'b1;
                    held_addr = bus.rd_addr_o;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    // Monitor: pops expected pixels on every strobe and watches strobe / row-level timing
    initial begin : monitor
        bit prev_rdy, prev_ss, row_seen;
        int low_run;
        prev_rdy = 0; prev_ss = 0; row_seen = 0; low_run = 0;
        forever begin
            @(negedge clk);
            if (!nreset) begin
                prev_rdy = 0; prev_ss = 0; row_seen = 0; low_run = 0;
            end else begin
                if (bus.px_rdy_o) begin
                    strobe_cnt++;
                    check("px_not_adjacent", prev_rdy, 0);
                    check("start_sobel_before_px", prev_ss, 1);
                    check("px_expected", exp_px_q.size() > 0, 1);
                    if (exp_px_q.size() > 0) check("px_data", bus.px_o, exp_px_q.pop_front());
                end
                if (bus.frame_done_o) begin
                    done_cnt++;
                    check("done_after_last_px", exp_px_q.size(), 0);
                end
                if (bus.cfg_err_o) err_cnt++;
                if (bus.start_sobel_o && !prev_ss && row_seen)
                    check("start_sobel_row_gap", low_run >= 3, 1);
                if (bus.start_sobel_o) begin
                    row_seen = 1;
                    low_run  = 0;
                end else begin
                    low_run++;
                end
                if (!bus.busy_o) row_seen = 0;
                prev_rdy = bus.px_rdy_o;
                prev_ss  = bus.start_sobel_o;
            end
        end
    end

    task automatic pulse_start(input int w, input int h, input logic [AB-1:0] base);
        @(posedge clk);
        #1;
        bus.img_width_i   = DB'(w);
        bus.img_height_i  = DB'(h);
        bus.base_addr_i   = base;
        bus.start_frame_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_frame_i = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        nreset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_addr_q.delete();
        exp_px_q.delete();
        nreset = 1'b1;
    endtask

    task automatic run_frame(input int w, input int h, input logic [AB-1:0] base,
                             input int dly, input bit disturb);
        int d0, s0, n;
        max_delay = dly;
        got_addr_q.delete();
        push_frame(w, h, base);
        d0 = done_cnt;
        s0 = strobe_cnt;
        pulse_start(w, h, base);
        n = 0;
        while (done_cnt == d0 && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
            if (disturb && n == 15) begin
                bus.start_frame_i = 1'b1;
                bus.img_width_i   = DB'(7);
                bus.img_height_i  = DB'(9);
                bus.base_addr_i   = 20'h00400;
            end
            if (disturb && n == 16) bus.start_frame_i = 1'b0;
        end
        check("frame_completes", n < 20000, 1);
        repeat (4) @(posedge clk);
        #1;
        check("frame_done_once", done_cnt - d0, 1);
        check("strobe_count", strobe_cnt - s0, 3 * w * (h - 2));
        check("all_reads_issued", exp_addr_q.size(), 0);
        check("idle_after_frame", bus.busy_o, 0);
        if (n >= 20000) do_reset();
    endtask

    task automatic cfg_err_case(input int w, input int h);
        int e0, d0;
        bit any_busy, any_req;
        e0 = err_cnt;
        d0 = done_cnt;
        any_busy = 0;
        any_req  = 0;
        pulse_start(w, h, 20'h00010);
        repeat (12) begin
            @(negedge clk);
            if (bus.busy_o) any_busy = 1;
            if (bus.rd_req_o) any_req = 1;
        end
        check("cfg_err_single_pulse", err_cnt - e0, 1);
        check("cfg_err_no_busy", any_busy, 0);
        check("cfg_err_no_read", any_req, 0);
        check("cfg_err_no_done", done_cnt - d0, 0);
    endtask

    task automatic abort_case();
        int d0, s0, n;
        resp_en = 1'b0;
        man_ack = 1'b0;
        push_frame(4, 3, 20'h0);
        d0 = done_cnt;
        s0 = strobe_cnt;
        pulse_start(4, 3, 20'h0);
        for (int i = 0; i < 6; i++) begin
            n = 0;
            while (!bus.rd_req_o && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("abort_req_seen", n < 50, 1);
            if (exp_addr_q.size() > 0) check("abort_rd_addr", bus.rd_addr_o, exp_addr_q.pop_front());
            man_data = mem_px(bus.rd_addr_o);
            man_ack  = 1'b1;
            if (i == 5) bus.abort_i = 1'b1;
            @(posedge clk);
            #1;
            man_ack     = 1'b0;
            bus.abort_i = 1'b0;
        end
        exp_addr_q.delete();
        exp_px_q.delete();
        @(negedge clk);
        check("abort_busy", bus.busy_o, 0);
        check("abort_rd_req", bus.rd_req_o, 0);
        check("abort_rd_addr_zero", bus.rd_addr_o, 0);
        check("abort_start_sobel", bus.start_sobel_o, 0);
        check("abort_px_rdy", bus.px_rdy_o, 0);
        repeat (6) @(negedge clk);
        check("abort_five_strobes", strobe_cnt - s0, 5);
        check("abort_no_done", done_cnt - d0, 0);
        resp_en = 1'b1;
        run_frame(4, 3, 20'h0, 1, 0);
        check("replay_count", got_addr_q.size(), 12);
        if (got_addr_q.size() > 0) check("replay_first_addr", got_addr_q[0], 0);
    endtask

    initial begin : main
        logic [AB-1:0] tbl [12];
        int w, h, d;
        logic [AB-1:0] b;

        tbl = '{20'd0, 20'd4, 20'd8, 20'd1, 20'd5, 20'd9, 20'd2, 20'd6, 20'd10, 20'd3, 20'd7, 20'd11};

        bus.start_frame_i = 1'b0;
        bus.abort_i       = 1'b0;
        bus.img_width_i   = '0;
        bus.img_height_i  = '0;
        bus.base_addr_i   = '0;

        #2 nreset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rd_req", bus.rd_req_o, 0);
        check("reset_rd_addr", bus.rd_addr_o, 0);
        check("reset_start_sobel", bus.start_sobel_o, 0);
        check("reset_px", bus.px_o, 0);
        check("reset_px_rdy", bus.px_rdy_o, 0);
        check("reset_busy", bus.busy_o, 0);
        check("reset_frame_done", bus.frame_done_o, 0);
        check("reset_cfg_err", bus.cfg_err_o, 0);
        @(posedge clk);
        #1;
        nreset = 1'b1;

        // 4x3 frame, immediate acks, explicit address order
        run_frame(4, 3, 20'h0, 0, 0);
        check("w4h3_count", got_addr_q.size(), 12);
        for (int i = 0; i < 12; i++)
            if (i < got_addr_q.size()) check("w4h3_addr", got_addr_q[i], tbl[i]);

        // 5x5 frame at base 100: three bands of 15 reads
        run_frame(5, 5, 20'd100, 0, 0);
        check("w5h5_count", got_addr_q.size(), 45);
        if (got_addr_q.size() == 45) begin
            check("w5h5_row0_start", got_addr_q[0], 100);
            check("w5h5_row1_start", got_addr_q[15], 105);
            check("w5h5_row2_start", got_addr_q[30], 110);
        end

        // rejected configurations
        cfg_err_case(2, 8);
        cfg_err_case(3, 2);

        // random ack delays
        run_frame(4, 3, 20'h0, 7, 0);
        check("w4h3_slow_count", got_addr_q.size(), 12);
        for (int i = 0; i < 12; i++)
            if (i < got_addr_q.size()) check("w4h3_slow_addr", got_addr_q[i], tbl[i]);

        // abort with a same-cycle ack, then replay
        abort_case();

        // start and width changes while busy must not matter
        run_frame(4, 3, 20'h0, 3, 1);

        // smallest legal frame and address wrap at the top of memory
        run_frame(3, 3, 20'h00020, 0, 0);
        run_frame(5, 4, 20'hFFFF8, 1, 0);

        // randomized frames
        for (int i = 0; i < 6; i++) begin
            w = $urandom_range(8, 3);
            h = $urandom_range(6, 3);
            d = $urandom_range(3, 0);
            b = AB'($urandom);
            run_frame(w, h, b, d, 0);
        end

        // reset in the middle of a frame
        push_frame(6, 4, 20'h00200);
        pulse_start(6, 4, 20'h00200);
        repeat (10) @(posedge clk);
        #1;
        nreset = 1'b0;
        #1;
        check("midreset_busy", bus.busy_o, 0);
        check("midreset_rd_req", bus.rd_req_o, 0);
        check("midreset_start_sobel", bus.start_sobel_o, 0);
        exp_addr_q.delete();
        exp_px_q.delete();
        @(posedge clk);
        #1;
        nreset = 1'b1;
        run_frame(3, 4, 20'h0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
